lda_scheduler: RTL and testbench
================================

LDA_SCHEDULER -- requirements
Module: lda_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of line requesters.
REQ-002 SHALL have parameter X_W, default 9, x-coordinate width.
REQ-003 SHALL have parameter Y_W, default 8, y-coordinate width.
REQ-004 SHALL have parameter C_W, default 3, colour width.
REQ-005 SHALL have parameter TIMEOUT, default 200000, max cycles allowed from o_start to i_lda_done.
REQ-006 SHALL have port i_clk  in  1  clock; all state on rising edge.
REQ-007 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port i_req  in  NUM_REQ  per-requester level request.
REQ-009 SHALL have port i_x0, i_x1  in  NUM_REQ*X_W  packed endpoint x per requester; slot i at bits [i*X_W +: X_W].
REQ-010 SHALL have port i_y0, i_y1  in  NUM_REQ*Y_W  packed endpoint y per requester.
REQ-011 SHALL have port i_color  in  NUM_REQ*C_W  packed colour per requester.
REQ-012 SHALL have port o_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-013 SHALL have port o_err  out  1  qualifies o_ack: line timed out.
REQ-014 SHALL have port o_busy  out  1  high in every state except S_IDLE.
REQ-015 SHALL have port o_grant_id  out  $clog2(NUM_REQ)  index of the current owner.
REQ-016 SHALL have port o_lda_start  out  1  one-cycle start pulse to line drawer.
REQ-017 SHALL have ports o_x0, o_x1 (X_W), o_y0, o_y1 (Y_W), o_color (C_W)  out  registered line parameters to the drawer.
REQ-018 SHALL have port i_lda_done  in  1  one-cycle completion pulse from the drawer.

Function
REQ-019 SHALL implement states S_IDLE, S_START, S_BUSY, S_ACK.
REQ-020 S_IDLE: if any i_req bit is high, SHALL pick the winner by round-robin, latch its coordinates, colour and index into the o_* registers, and go to S_START; else stay.
REQ-021 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward with wrap; last_grant resets to NUM_REQ-1, so requester 0 has priority first.
REQ-022 S_START SHALL assert o_lda_start for exactly one cycle, clear the timeout counter, and go to S_BUSY.
REQ-023 S_BUSY SHALL increment the counter each cycle; on i_lda_done SHALL go to S_ACK with err=0; on counter==TIMEOUT-1 without done SHALL go to S_ACK with err=1.
REQ-024 If i_lda_done and the timeout coincide, done SHALL win (err=0).
REQ-025 S_ACK SHALL pulse o_ack[grant_id] for one cycle, with o_err equal to the latched err, set last_grant=grant_id, and return to S_IDLE.
REQ-026 Latency SHALL be: request sampled in S_IDLE at cycle T, o_lda_start at T+1, o_ack the cycle after i_lda_done.
REQ-027 o_x0..o_color and o_grant_id SHALL hold stable from S_START through S_ACK.
REQ-028 Requesters SHALL drop i_req the cycle after o_ack; a bit still high in S_IDLE SHALL be treated as a new request.
REQ-029 i_req changes or withdrawal while not in S_IDLE SHALL be ignored; i_lda_done outside S_BUSY SHALL be ignored.
REQ-030 The counter SHALL saturate and never wrap.

Reset
REQ-031 Reset SHALL force S_IDLE, last_grant=NUM_REQ-1, counter=0, err=0.
REQ-032 Reset SHALL force all outputs to 0; a reset mid-line SHALL abandon the line with no o_ack and no further o_lda_start.

Structure
REQ-033 Package lda_sched_pkg SHALL hold the state enum and the default width and timeout constants.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: req, last_grant; outputs: valid, index).

Verification
REQ-035 Single: i_req=0001, line (0,0)-(10,5), done 12 cycles after start -> o_lda_start at T+1, o_x1=10, o_ack=0001 with o_err=0 the cycle after done.
REQ-036 Fairness: i_req=1111 held, each ack followed by a drop-and-reassert -> grant order 0,1,2,3,0.
REQ-037 Timeout: TIMEOUT=16, done never arrives -> o_ack=0100 with o_err=1 exactly 16 cycles after the S_BUSY entry.
REQ-038 Coincidence: done on the same cycle the counter reaches TIMEOUT-1 -> o_err=0.
REQ-039 Reset in S_BUSY -> all outputs 0 next edge, no ack; next i_req=0010 -> grant_id=1.
REQ-040 Stray i_lda_done in S_IDLE and a requester change during S_BUSY -> no state change; latched coordinates unchanged.

Source files
------------

// File: rtl/lda_sched_pkg.sv
// Shared definitions for the line-drawer scheduler: FSM state encoding and
// default geometry / timeout constants.
package lda_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_X_W     = 9;
    localparam int DEF_Y_W     = 8;
    localparam int DEF_C_W     = 3;
    localparam int DEF_TIMEOUT = 200000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/lda_scheduler_rr_arbiter.sv
// Round-robin requester selection. Searches upward from the slot after the
// previous owner, wrapping, and reports the first active requester found.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               valid,
    output logic [ID_W-1:0]    index
);

    // First active requester at distance 1..NUM_REQ from the previous owner.
    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned, which would infer a latch.
        valid = 1'b0;
        index = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!valid && req[ID_W'((int'(last_grant) + k) % NUM_REQ)]) begin
                valid = 1'b1;
                index = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/lda_scheduler.sv
// Shares one line drawer between several requesters. A round-robin winner's
// line parameters are latched, the drawer is started, and completion (or a
// timeout) is reported back to the owner as a one-hot ack.
module lda_scheduler
    import lda_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int C_W     = DEF_C_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*X_W-1:0]     i_x0,
    input  logic [NUM_REQ*X_W-1:0]     i_x1,
    input  logic [NUM_REQ*Y_W-1:0]     i_y0,
    input  logic [NUM_REQ*Y_W-1:0]     i_y1,
    input  logic [NUM_REQ*C_W-1:0]     i_color,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_err,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_lda_start,
    output logic [X_W-1:0]             o_x0,
    output logic [X_W-1:0]             o_x1,
    output logic [Y_W-1:0]             o_y0,
    output logic [Y_W-1:0]             o_y1,
    output logic [C_W-1:0]             o_color,
    input  logic                       i_lda_done
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [CNT_W-1:0]   cnt;
    logic               err;
    logic               arb_valid;
    logic [ID_W-1:0]    arb_index;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (i_req),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .index      (arb_index)
    );

    // Scheduler FSM; every output is a register updated alongside the state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            cnt         <= '0;
            err         <= 1'b0;
            o_ack       <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_grant_id  <= '0;
            o_lda_start <= 1'b0;
            o_x0        <= '0;
            o_x1        <= '0;
            o_y0        <= '0;
            o_y1        <= '0;
            o_color     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
            o_lda_start <= 1'b0;
            o_ack       <= '0;
            o_err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        o_grant_id  <= arb_index;
                        o_x0        <= i_x0[int'(arb_index)*X_W +: X_W];
                        o_x1        <= i_x1[int'(arb_index)*X_W +: X_W];
                        o_y0        <= i_y0[int'(arb_index)*Y_W +: Y_W];
                        o_y1        <= i_y1[int'(arb_index)*Y_W +: Y_W];
                        o_color     <= i_color[int'(arb_index)*C_W +: C_W];
                        o_lda_start <= 1'b1;
                        o_busy      <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    err   <= 1'b0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    // Done takes precedence over a timeout on the same cycle.
                    if (i_lda_done) begin
                        err   <= 1'b0;
                        o_err <= 1'b0;
                        o_ack <= NUM_REQ'(1) << o_grant_id;
                        state <= S_ACK;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        o_err <= 1'b1;
                        o_ack <= NUM_REQ'(1) << o_grant_id;
                        state <= S_ACK;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    last_grant <= o_grant_id;
                    o_busy     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lda_scheduler.sv
// Self-checking bench for lda_scheduler: directed scenarios plus randomized
// lines, checked against a round-robin / latency model written from the
// behavioural rules (who wins, when the ack lands, whether it is an error).
module tb_lda_scheduler;

    localparam int NUM_REQ = 4;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int C_W     = 3;
    localparam int TIMEOUT = 16;
    localparam int ID_W    = 2;
    localparam int LAT_W   = 2*X_W + 2*Y_W + C_W + ID_W;
    localparam int ALL_W   = NUM_REQ + 1 + 1 + ID_W + 1 + LAT_W - ID_W;

    logic                   i_clk = 1'b0;
    logic                   i_reset;
    logic [NUM_REQ-1:0]     i_req;
    logic [NUM_REQ*X_W-1:0] i_x0, i_x1;
    logic [NUM_REQ*Y_W-1:0] i_y0, i_y1;
    logic [NUM_REQ*C_W-1:0] i_color;
    logic [NUM_REQ-1:0]     o_ack;
    logic                   o_err, o_busy, o_lda_start, i_lda_done;
    logic [ID_W-1:0]        o_grant_id;
    logic [X_W-1:0]         o_x0, o_x1;
    logic [Y_W-1:0]         o_y0, o_y1;
    logic [C_W-1:0]         o_color;

    lda_scheduler #(
        .NUM_REQ (NUM_REQ), .X_W (X_W), .Y_W (Y_W), .C_W (C_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_x0        (i_x0),
        .i_x1        (i_x1),
        .i_y0        (i_y0),
        .i_y1        (i_y1),
        .i_color     (i_color),
        .o_ack       (o_ack),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id),
        .o_lda_start (o_lda_start),
        .o_x0        (o_x0),
        .o_x1        (o_x1),
        .o_y0        (o_y0),
        .o_y1        (o_y1),
        .o_color     (o_color),
        .i_lda_done  (i_lda_done)
    );

    always #5 i_clk = ~i_clk;

    logic [LAT_W-1:0] latched;
    logic [ALL_W-1:0] all_out;
    assign latched = {o_x0, o_x1, o_y0, o_y1, o_color, o_grant_id};
    assign all_out = {o_ack, o_err, o_busy, o_lda_start, latched};

    int checks = 0;
    int errors = 0;
    int exp_last;
    logic [LAT_W-1:0] last_lat;

    logic [X_W-1:0] x0_a [NUM_REQ];
    logic [X_W-1:0] x1_a [NUM_REQ];
    logic [Y_W-1:0] y0_a [NUM_REQ];
    logic [Y_W-1:0] y1_a [NUM_REQ];
    logic [C_W-1:0] c_a  [NUM_REQ];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_coords();
        for (int i = 0; i < NUM_REQ; i++) begin
            i_x0[i*X_W +: X_W]    = x0_a[i];
            i_x1[i*X_W +: X_W]    = x1_a[i];
            i_y0[i*Y_W +: Y_W]    = y0_a[i];
            i_y1[i*Y_W +: Y_W]    = y1_a[i];
            i_color[i*C_W +: C_W] = c_a[i];
        end
    endtask

    task automatic rand_coords();
        for (int i = 0; i < NUM_REQ; i++) begin
            x0_a[i] = X_W'($urandom);
            x1_a[i] = X_W'($urandom);
            y0_a[i] = Y_W'($urandom);
            y1_a[i] = Y_W'($urandom);
            c_a[i]  = C_W'($urandom);
        end
        drive_coords();
    endtask

    // Reference: the owner is the first active requester met when walking
    // upward from the slot after the previous owner, wrapping around.
    function automatic int model_pick(input logic [NUM_REQ-1:0] r);
        int order[$];
        for (int k = 1; k <= NUM_REQ; k++) order.push_back((exp_last + k) % NUM_REQ);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    // One complete line. done_k: i_lda_done is pulsed k cycles after S_BUSY
    // entry (negative = never). Ack is expected k+1 cycles after entry when
    // k <= TIMEOUT-1, otherwise TIMEOUT cycles after entry flagged as error.
    task automatic run_line(input logic [NUM_REQ-1:0] req, input int done_k,
                            input bit new_coords, input bit disturb,
                            input string tag, output int obs_grant);
        int win, ack_off;
        bit exp_err, early, got_ack;
        logic [LAT_W-1:0] exp_lat;
        if (new_coords) rand_coords(); else drive_coords();
        win     = model_pick(req);
        exp_lat = {x0_a[win], x1_a[win], y0_a[win], y1_a[win], c_a[win], ID_W'(win)};
        exp_err = !(done_k >= 0 && done_k <= TIMEOUT - 1);
        ack_off = exp_err ? TIMEOUT : done_k + 1;
        i_req   = req;
        tick();
        obs_grant = int'(o_grant_id);
        checks++;
        if (o_lda_start !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start: start=%b busy=%b expected 1 1", tag, o_lda_start, o_busy);
        end
        checks++;
        if (latched !== exp_lat) begin
            errors++;
            $display("FAIL %s latch: got %h expected %h", tag, latched, exp_lat);
        end
        tick();
        checks++;
        if (o_lda_start !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_pulse_width: start=%b busy=%b expected 0 1", tag, o_lda_start, o_busy);
        end
        early   = 1'b0;
        got_ack = 1'b0;
        for (int k = 0; k < TIMEOUT + 4 && !got_ack; k++) begin
            i_lda_done = (k == done_k);
            if (disturb && k == 2) begin
                i_req = ~req;
                rand_coords();
            end
            tick();
            i_lda_done = 1'b0;
            if (k + 1 == ack_off) begin
                got_ack = 1'b1;
                checks++;
                if ({o_ack, o_err} !== {NUM_REQ'(1) << win, exp_err}) begin
                    errors++;
                    $display("FAIL %s ack: ack=%b err=%b expected ack=%b err=%b",
                             tag, o_ack, o_err, NUM_REQ'(1) << win, exp_err);
                end
                checks++;
                if (latched !== exp_lat) begin
                    errors++;
                    $display("FAIL %s hold: got %h expected %h", tag, latched, exp_lat);
                end
            end else if (o_ack !== '0) begin
                early = 1'b1;
            end
        end
        checks++;
        if (early || !got_ack) begin
            errors++;
            $display("FAIL %s ack_timing: early=%b seen=%b expected 0 1", tag, early, got_ack);
        end
        exp_last = win;
        last_lat = exp_lat;
        tick();
        i_req = '0;
        checks++;
        if (o_ack !== '0 || o_busy !== 1'b0 || o_lda_start !== 1'b0) begin
            errors++;
            $display("FAIL %s return_idle: ack=%b busy=%b start=%b expected 0 0 0",
                     tag, o_ack, o_busy, o_lda_start);
        end
        tick();
    endtask

    task automatic apply_reset();
        i_reset    = 1'b1;
        i_req      = '0;
        i_lda_done = 1'b0;
        tick();
        tick();
        i_reset  = 1'b0;
        exp_last = NUM_REQ - 1;
        tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        i_reset  = 1'b0;
        exp_last = NUM_REQ - 1;
        tick();
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", all_out);
        end
    endtask

    task automatic test_single();
        int g;
        for (int i = 0; i < NUM_REQ; i++) begin
            x0_a[i] = X_W'(i + 100); x1_a[i] = X_W'(i + 200);
            y0_a[i] = Y_W'(i + 50);  y1_a[i] = Y_W'(i + 60);  c_a[i] = C_W'(i);
        end
        x0_a[0] = '0; y0_a[0] = '0; x1_a[0] = 9'd10; y1_a[0] = 8'd5; c_a[0] = 3'd6;
        run_line(4'b0001, 11, 1'b0, 1'b0, "single", g);
        checks++;
        if (last_lat[LAT_W-X_W-1 -: X_W] !== 9'd10 || g != 0) begin
            errors++;
            $display("FAIL single_x1: x1=%0d grant=%0d expected 10 0", last_lat[LAT_W-X_W-1 -: X_W], g);
        end
    endtask

    task automatic test_fairness();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int g;
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            run_line(4'b1111, int'($urandom_range(0, 8)), 1'b1, 1'b0, "fair", g);
            checks++;
            if (g != exp_order[n]) begin
                errors++;
                $display("FAIL fairness_%0d: grant %0d expected %0d", n, g, exp_order[n]);
            end
        end
    endtask

    task automatic test_timeout();
        int g;
        run_line(4'b0100, -1, 1'b1, 1'b0, "timeout", g);
    endtask

    task automatic test_coincide();
        int g;
        run_line(4'b0010, TIMEOUT - 1, 1'b1, 1'b0, "coincide", g);
        run_line(4'b1000, TIMEOUT, 1'b1, 1'b0, "done_late", g);
    endtask

    task automatic test_reset_mid();
        bit bad;
        int g;
        rand_coords();
        i_req = 4'b0100;
        tick();
        tick();
        i_req = '0;
        tick();
        tick();
        i_reset = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", all_out);
        end
        tick();
        i_reset  = 1'b0;
        exp_last = NUM_REQ - 1;
        bad = 1'b0;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            i_lda_done = (k == 3);
            tick();
            i_lda_done = 1'b0;
            if (o_ack !== '0 || o_lda_start !== 1'b0 || o_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_abandon: activity seen after reset, expected none");
        end
        run_line(4'b0010, 4, 1'b1, 1'b0, "after_reset", g);
        checks++;
        if (g != 1) begin
            errors++;
            $display("FAIL after_reset_grant: grant %0d expected 1", g);
        end
    endtask

    task automatic test_stray();
        int g;
        i_req      = '0;
        i_lda_done = 1'b1;
        tick();
        i_lda_done = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_ack !== '0 || o_lda_start !== 1'b0 || latched !== last_lat) begin
            errors++;
            $display("FAIL stray_done: busy=%b ack=%b start=%b lat=%h expected 0 0 0 %h",
                     o_busy, o_ack, o_lda_start, latched, last_lat);
        end
        run_line(4'b0101, 7, 1'b1, 1'b1, "disturb", g);
    endtask

    task automatic test_random();
        int g;
        for (int n = 0; n < 12; n++) begin
            run_line(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)),
                     int'($urandom_range(0, TIMEOUT + 1)), 1'b1, n[0], "random", g);
        end
    endtask

    initial begin
        i_reset    = 1'b1;
        i_req      = '0;
        i_lda_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            x0_a[i] = '0; x1_a[i] = '0; y0_a[i] = '0; y1_a[i] = '0; c_a[i] = '0;
        end
        drive_coords();
        last_lat = '0;
        exp_last = NUM_REQ - 1;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_stray();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
